// File: rtl/mod_field_counter.sv
// Modulo-N clock/calendar field counter with carry chaining, button auto-repeat,
// synchronous load and a BCD split of the count.
module mod_field_counter #(
    parameter int WIDTH      = 6,
    parameter int MODULUS    = 60,
    parameter int RST_VAL    = 0,
    parameter int REPEAT_DLY = 3,
    parameter int REPEAT_PER = 1
) (
    input  logic             sig_1Hz,
    input  logic             reset,
    input  logic             carry_in,
    input  logic             inc_b,
    input  logic             dec_b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] ctr,
    output logic             carry_out,
    output logic [3:0]       tens,
    output logic [3:0]       ones
);

    // state   | meaning
    // IDLE    | no button held; a valid sample is a new press (one step)
    // DELAY   | press seen, counting hold clocks until auto-repeat starts
    // REPEAT  | auto-repeat, one step every REPEAT_PER clocks
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
    typedef enum logic {DIR_INC, DIR_DEC} dir_t;
    typedef enum logic [1:0] {SMP_NONE, SMP_INC, SMP_DEC} smp_t;

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int EW      = (WIDTH > 8) ? WIDTH : 8;

    localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_CTR = WIDTH'(RST_VAL);
    localparam logic [CW-1:0]    DLY_C   = CW'(REPEAT_DLY);
    localparam logic [CW-1:0]    PER_C   = CW'(REPEAT_PER);
    localparam logic [CW-1:0]    SAT_C   = CW'(CNT_MAX);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [CW-1:0]    per_q, per_d;
    logic [WIDTH-1:0] ctr_q, ctr_d;

    smp_t             smp;
    dir_t             smp_dir;
    logic             btn_step;
    logic [CW-1:0]    hold_inc;
    logic [CW-1:0]    per_inc;
    logic             step_up;
    logic             step_dn;
    logic [WIDTH-1:0] ctr_inc;
    logic [WIDTH-1:0] ctr_dec;
    logic [WIDTH-1:0] load_clip;
    logic [EW-1:0]    ctr_ext;

    always_comb begin
        smp = SMP_NONE;
        if (inc_b && !dec_b) begin
            smp = SMP_INC;
        end else if (dec_b && !inc_b) begin
            smp = SMP_DEC;
        end
        smp_dir = (smp == SMP_DEC) ? DIR_DEC : DIR_INC;
    end

    assign hold_inc = (hold_q == SAT_C) ? hold_q : hold_q + CW'(1);
    assign per_inc  = (per_q == SAT_C) ? per_q : per_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hold_d   = hold_q;
        per_d    = per_q;
        btn_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (smp != SMP_NONE) begin
                    btn_step = 1'b1;
                    dir_d    = smp_dir;
                    state_d  = ST_DELAY;
                    hold_d   = CW'(1);
                    per_d    = '0;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (smp == SMP_NONE) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                    per_d   = '0;
                end else if (smp_dir != dir_q) begin
                    // reversing direction mid-hold behaves like a fresh press
                    btn_step = 1'b1;
                    dir_d    = smp_dir;
                    state_d  = ST_DELAY;
                    hold_d   = CW'(1);
                    per_d    = '0;
                end else if (state_q == ST_DELAY) begin
                    if (hold_q >= DLY_C) begin
                        btn_step = 1'b1;
                        state_d  = ST_REPEAT;
                        hold_d   = '0;
                        per_d    = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end else begin
                    if (per_inc >= PER_C) begin
                        btn_step = 1'b1;
                        per_d    = '0;
                    end else begin
                        per_d = per_inc;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
                per_d   = '0;
            end
        endcase
    end

    // the step direction is the one latched this clock, so a reversal steps the new way
    assign step_up   = carry_in | (btn_step & (dir_d == DIR_INC));
    assign step_dn   = btn_step & (dir_d == DIR_DEC);
    assign ctr_inc   = (ctr_q == TOP_VAL) ? '0 : ctr_q + WIDTH'(1);
    assign ctr_dec   = (ctr_q == '0) ? TOP_VAL : ctr_q - WIDTH'(1);
    assign load_clip = (32'(load_val) < 32'(MODULUS)) ? load_val : TOP_VAL;

    always_comb begin
        ctr_d = ctr_q;
        if (load) begin
            ctr_d = load_clip;
        end else if (step_up && !step_dn) begin
            ctr_d = ctr_inc;
        end else if (step_dn && !step_up) begin
            ctr_d = ctr_dec;
        end
    end

    always_ff @(posedge sig_1Hz) begin
        if (reset) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_INC;
            hold_q  <= '0;
            per_q   <= '0;
            ctr_q   <= RST_CTR;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            hold_q  <= hold_d;
            per_q   <= per_d;
            ctr_q   <= ctr_d;
        end
    end

    // only the carry chain ripples onward; button steps never reach carry_out
    assign carry_out = carry_in & (ctr_q == TOP_VAL) & ~load & ~reset;
    assign ctr       = ctr_q;

    assign ctr_ext = EW'(ctr_q);
    assign tens    = 4'(ctr_ext / EW'(10));
    assign ones    = 4'(ctr_ext % EW'(10));

endmodule

// File: tb/tb_mod_field_counter.sv
// Bench for mod_field_counter: directed scenarios plus a randomized run against
// a hold-time based behavioural model.
module tb_mod_field_counter;

    localparam int W    = 6;
    localparam int M    = 60;
    localparam int RV   = 5;
    localparam int DLY  = 3;
    localparam int PER  = 1;

    logic         sig_1Hz = 1'b0;
    logic         reset = 1'b0;
    logic         carry_in = 1'b0;
    logic         inc_b = 1'b0;
    logic         dec_b = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] ctr;
    logic         carry_out;
    logic [3:0]   tens;
    logic [3:0]   ones;

    int tests_run = 0;
    int tests_failed = 0;

    // model: count value, whether a press is active, its direction and clocks held
    int m_ctr = 0;
    bit m_active = 0;
    int m_dir = 0;
    int m_k = 0;

    mod_field_counter #(
        .WIDTH(W), .MODULUS(M), .RST_VAL(RV), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) u_dut (
        .sig_1Hz  (sig_1Hz),
        .reset    (reset),
        .carry_in (carry_in),
        .inc_b    (inc_b),
        .dec_b    (dec_b),
        .load     (load),
        .load_val (load_val),
        .ctr      (ctr),
        .carry_out(carry_out),
        .tens     (tens),
        .ones     (ones)
    );

    always #5 sig_1Hz = ~sig_1Hz;

    function automatic bit exp_carry();
        return carry_in && (m_ctr == M - 1) && !load && !reset;
    endfunction

    // advance the model by one clock from current inputs, then clock the DUT
    task automatic step_clk();
        int s;
        bit btn;
        bit up;
        bit dn;
        s   = (inc_b && !dec_b) ? 1 : ((dec_b && !inc_b) ? -1 : 0);
        btn = 0;
        if (reset) begin
            m_ctr    = RV;
            m_active = 0;
        end else begin
            if (s == 0) begin
                m_active = 0;
            end else if (!m_active || s != m_dir) begin
                m_active = 1;
                m_dir    = s;
                m_k      = 0;
            end else begin
                m_k++;
            end
            if (m_active)
                btn = (m_k == 0) || (m_k >= DLY && ((m_k - DLY) % PER) == 0);
            up = carry_in || (btn && m_dir == 1);
            dn = btn && m_dir == -1;
            if (load)
                m_ctr = (int'(load_val) < M) ? int'(load_val) : M - 1;
            else if (up && !dn)
                m_ctr = (m_ctr + 1) % M;
            else if (dn && !up)
                m_ctr = (m_ctr + M - 1) % M;
        end
        @(posedge sig_1Hz);
        #1;
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = W'(v);
        step_clk();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        tests_run++;
        if (ctr !== W'(RV)) begin
            tests_failed++;
            $display("FAIL reset_ctr got=%0d exp=%0d", ctr, RV);
        end
        tests_run++;
        if (tens !== 4'd0 || ones !== 4'd5) begin
            tests_failed++;
            $display("FAIL reset_bcd got=%0d%0d exp=05", tens, ones);
        end
        do_load(59);
        reset    = 1'b1;
        carry_in = 1'b1;
        #1;
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_carry_forced got=%b exp=0", carry_out);
        end
        step_clk();
        reset    = 1'b0;
        carry_in = 1'b0;
        tests_run++;
        if (ctr !== W'(RV)) begin
            tests_failed++;
            $display("FAIL reset_over_carry got=%0d exp=%0d", ctr, RV);
        end
    endtask

    task automatic test_wrap();
        do_load(59);
        carry_in = 1'b1;
        #1;
        tests_run++;
        if (carry_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_carry_out got=%b exp=1", carry_out);
        end
        step_clk();
        carry_in = 1'b0;
        tests_run++;
        if (ctr !== '0 || tens !== 4'd0 || ones !== 4'd0) begin
            tests_failed++;
            $display("FAIL wrap_ctr got=%0d (%0d,%0d) exp=0 (0,0)", ctr, tens, ones);
        end
    endtask

    task automatic test_repeat();
        int exp_seq[7] = '{11, 11, 11, 12, 13, 14, 15};
        do_load(10);
        inc_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step_clk();
            tests_run++;
            if (ctr !== W'(exp_seq[i])) begin
                tests_failed++;
                $display("FAIL repeat_clk%0d got=%0d exp=%0d", i, ctr, exp_seq[i]);
            end
        end
        inc_b = 1'b0;
        for (int i = 0; i < 3; i++) step_clk();
        tests_run++;
        if (ctr !== W'(15) || tens !== 4'd1 || ones !== 4'd5) begin
            tests_failed++;
            $display("FAIL repeat_release got=%0d exp=15", ctr);
        end
    endtask

    task automatic test_dec_wrap();
        do_load(0);
        dec_b = 1'b1;
        #1;
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL decwrap_carry_pre got=%b exp=0", carry_out);
        end
        step_clk();
        dec_b = 1'b0;
        tests_run++;
        if (ctr !== W'(59) || carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL decwrap got=%0d co=%b exp=59 co=0", ctr, carry_out);
        end
    endtask

    task automatic test_simultaneous();
        do_load(30);
        carry_in = 1'b1;
        dec_b    = 1'b1;
        step_clk();
        carry_in = 1'b0;
        dec_b    = 1'b0;
        tests_run++;
        if (ctr !== W'(30)) begin
            tests_failed++;
            $display("FAIL carry_vs_dec got=%0d exp=30", ctr);
        end
        step_clk();
        inc_b = 1'b1;
        dec_b = 1'b1;
        for (int i = 0; i < 5; i++) step_clk();
        inc_b = 1'b0;
        dec_b = 1'b0;
        tests_run++;
        if (ctr !== W'(30)) begin
            tests_failed++;
            $display("FAIL both_buttons got=%0d exp=30", ctr);
        end
    endtask

    task automatic test_load();
        do_load(63);
        tests_run++;
        if (ctr !== W'(59)) begin
            tests_failed++;
            $display("FAIL load_clip got=%0d exp=59", ctr);
        end
        load     = 1'b1;
        load_val = W'(42);
        carry_in = 1'b1;
        #1;
        tests_run++;
        if (carry_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_blocks_carry got=%b exp=0", carry_out);
        end
        step_clk();
        load     = 1'b0;
        carry_in = 1'b0;
        tests_run++;
        if (ctr !== W'(42) || tens !== 4'd4 || ones !== 4'd2) begin
            tests_failed++;
            $display("FAIL load_42 got=%0d exp=42", ctr);
        end
    endtask

    task automatic test_reset_mid_repeat();
        do_load(20);
        inc_b = 1'b1;
        for (int i = 0; i < 6; i++) step_clk();
        reset = 1'b1;
        step_clk();
        reset = 1'b0;
        tests_run++;
        if (ctr !== W'(RV)) begin
            tests_failed++;
            $display("FAIL midrep_reset got=%0d exp=%0d", ctr, RV);
        end
        step_clk();
        tests_run++;
        if (ctr !== W'(RV + 1)) begin
            tests_failed++;
            $display("FAIL midrep_new_press got=%0d exp=%0d", ctr, RV + 1);
        end
        step_clk();
        tests_run++;
        if (ctr !== W'(RV + 1)) begin
            tests_failed++;
            $display("FAIL midrep_delay got=%0d exp=%0d", ctr, RV + 1);
        end
        inc_b = 1'b0;
        step_clk();
    endtask

    task automatic test_random();
        bit ec;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5, 0) == 0) begin
                case ($urandom_range(3, 0))
                    0: begin inc_b = 1'b0; dec_b = 1'b0; end
                    1: begin inc_b = 1'b1; dec_b = 1'b0; end
                    2: begin inc_b = 1'b0; dec_b = 1'b1; end
                    default: begin inc_b = 1'b1; dec_b = 1'b1; end
                endcase
            end
            carry_in = ($urandom_range(2, 0) == 0);
            load     = ($urandom_range(19, 0) == 0);
            load_val = W'($urandom_range(63, 0));
            reset    = ($urandom_range(49, 0) == 0);
            #1;
            ec = exp_carry();
            tests_run++;
            if (carry_out !== ec) begin
                tests_failed++;
                $display("FAIL rnd_carry n=%0d got=%b exp=%b", n, carry_out, ec);
            end
            step_clk();
            tests_run++;
            if (ctr !== W'(m_ctr) || tens !== 4'(m_ctr / 10) || ones !== 4'(m_ctr % 10)) begin
                tests_failed++;
                $display("FAIL rnd_ctr n=%0d got=%0d (%0d,%0d) exp=%0d", n, ctr, tens, ones, m_ctr);
            end
        end
        reset    = 1'b0;
        load     = 1'b0;
        carry_in = 1'b0;
        inc_b    = 1'b0;
        dec_b    = 1'b0;
        step_clk();
    endtask

    initial begin
        @(posedge sig_1Hz);
        #1;
        test_reset();
        test_wrap();
        test_repeat();
        test_dec_wrap();
        test_simultaneous();
        test_load();
        test_reset_mid_repeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mod_field_counter.md
MOD_FIELD_COUNTER -- requirements
Module: mod_field_counter

Interface
REQ-001 Parameter WIDTH, default 6: counter width in bits.
REQ-002 Parameter MODULUS, default 60: count range 0..MODULUS-1; legal range 2..min(2^WIDTH,100).
REQ-003 Parameter RST_VAL, default 0: value loaded by reset; legal range 0..MODULUS-1.
REQ-004 Parameter REPEAT_DLY, default 3: clocks a button is held before auto-repeat starts; legal value >=1.
REQ-005 Parameter REPEAT_PER, default 1: clocks between auto-repeat steps; legal value >=1.
REQ-006 sig_1Hz  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 carry_in  in  1  step enable from the lower field, e.g. seconds==59.
REQ-009 inc_b  in  1  level-sensitive increment button, already synchronised.
REQ-010 dec_b  in  1  level-sensitive decrement button, already synchronised.
REQ-011 load  in  1  synchronous load strobe.
REQ-012 load_val  in  WIDTH  value for load.
REQ-013 ctr  out  WIDTH  registered count.
REQ-014 carry_out  out  1  wrap indication to the next field.
REQ-015 tens  out  4  BCD tens digit of ctr.
REQ-016 ones  out  4  BCD ones digit of ctr.

Function
REQ-017 The block SHALL keep a button FSM with states IDLE, DELAY and REPEAT, and SHALL track the active direction: INC or DEC.
REQ-018 Button sample SHALL be INC when only inc_b=1, DEC when only dec_b=1, and NONE otherwise, including when both are 1.
REQ-019 IDLE transitions:
- sample INC or DEC: issue one step in that direction in the same clock, latch the direction, enter DELAY with hold counter=1.
- sample NONE: stay in IDLE.
REQ-020 DELAY behaviour:
- sample equals the latched direction: increment the hold counter each clock.
- hold counter reaches REPEAT_DLY: issue one step and enter REPEAT with period counter=0.
REQ-021 REPEAT behaviour: while the sample equals the latched direction, issue one step every REPEAT_PER clocks.
REQ-022 In DELAY or REPEAT, a sample of NONE SHALL return the FSM to IDLE with no step issued.
REQ-023 In DELAY or REPEAT, a sample of the opposite direction SHALL count as a new press: step once in the new direction, latch it, and re-enter DELAY with hold counter=1.
REQ-024 Net update per clock:
- up = carry_in OR button INC step; dn = button DEC step.
- up and dn both set: ctr holds.
- up only: ctr increments; dn only: ctr decrements.
REQ-025 Increment from MODULUS-1 SHALL wrap to 0; decrement from 0 SHALL wrap to MODULUS-1.
REQ-026 Update priority SHALL be reset > load > step.
- load=1: ctr <= load_val if load_val < MODULUS, else MODULUS-1.
- load=1: the step is discarded, but the FSM still advances.
REQ-027 carry_out SHALL be combinational: carry_in AND (ctr==MODULUS-1) AND NOT load AND NOT reset.
REQ-028 Button steps SHALL never assert carry_out, so manual setting does not ripple into the next field.
REQ-029 tens SHALL equal ctr/10 and ones SHALL equal ctr%10, combinationally from ctr.
REQ-030 All internal counters SHALL be sized to hold max(REPEAT_DLY,REPEAT_PER) and SHALL saturate rather than overflow.
REQ-031 ctr SHALL never hold a value >= MODULUS.

Reset
REQ-032 With reset=1 at a clock edge, the block SHALL set ctr=RST_VAL, FSM=IDLE, all counters=0 and direction=INC.
REQ-033 While reset=1, the block SHALL force carry_out=0.
REQ-034 Reset SHALL override load, carry_in and buttons.
REQ-035 A button held through reset release SHALL count as a new press on the first clock after release.

Verification
REQ-036 Wrap: ctr=59, carry_in=1 one clock -> carry_out=1 before the edge; ctr=0, tens=0, ones=0 after the edge.
REQ-037 Repeat, defaults: inc_b high 7 clocks from ctr=10 -> steps at clocks 0, 3, 4, 5, 6; ctr=15; release -> IDLE, ctr stays 15.
REQ-038 Decrement wrap: ctr=0, dec_b pulse 1 clock -> ctr=59, carry_out stays 0.
REQ-039 Simultaneous events:
- carry_in=1 with a new dec_b press at ctr=30 -> ctr=30.
- inc_b=dec_b=1 -> no button step.
REQ-040 Load: load=1, load_val=63 -> ctr=59; load=1, load_val=42 with carry_in=1 -> ctr=42, carry_out=0.
REQ-041 Reset mid-repeat: RST_VAL=5, reset=1 during REPEAT -> ctr=5, FSM=IDLE; inc_b still high after release -> one step, ctr=6.
